// File: rtl/tc_disp_pkg.sv
// Shared types and constants for the time-shared hex display scheduler.
package tc_disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDecode,
    StWrite
  } state_e;

  localparam int unsigned NchDefault   = 4;
  localparam logic [6:0]  BlankPattern = 7'h7F;

  // Width of a channel index; at least one bit even for tiny channel counts.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: lowest requesting index at or after rr_ptr, wrapping modulo NCH.
module rr_arbiter
  import tc_disp_pkg::*;
#(
  parameter int unsigned NCH = NchDefault,
  localparam int unsigned PW = ptr_width(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  rr_ptr,
  output logic [PW-1:0]  winner,
  output logic           any
);

  // Scan from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % int'(NCH)]) begin
        winner = PW'((int'(rr_ptr) + k) % int'(NCH));
      end
    end
  end

endmodule

// File: rtl/tc_hex_scheduler.sv
// Time-shares one external two's-complement 7-segment decoder among NCH channels,
// each update taking GRANT -> DECODE -> WRITE with round-robin arbitration.
module tc_hex_scheduler
  import tc_disp_pkg::*;
#(
  parameter int unsigned NCH   = NchDefault,
  parameter logic [6:0]  BLANK = BlankPattern
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [NCH-1:0]   req,
  input  logic [4*NCH-1:0] val,
  output logic [NCH-1:0]   ack,
  output logic [3:0]       dec_n,
  input  logic [6:0]       dec_sign,
  input  logic [6:0]       dec_mag,
  output logic [7*NCH-1:0] hex_sign,
  output logic [7*NCH-1:0] hex_mag,
  output logic             busy
);

  localparam int unsigned PW = ptr_width(NCH);

  state_e           state_q;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    win_q;
  logic [PW-1:0]    winner;
  logic             any;
  logic             launch;
  logic [NCH-1:0]   ack_q, grant_d;
  logic [3:0]       dec_n_q;
  logic [6:0]       sign_q, mag_q;
  logic [7*NCH-1:0] hex_sign_q, hex_mag_q;

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    rr_ptr_d = (winner == PW'(NCH - 1)) ? '0 : winner + 1'b1;
    grant_d  = NCH'(1) << winner;
    launch   = any && ((state_q == StIdle) || (state_q == StWrite));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      win_q      <= '0;
      ack_q      <= '0;
      dec_n_q    <= '0;
      sign_q     <= BLANK;
      mag_q      <= BLANK;
      hex_sign_q <= {NCH{BLANK}};
      hex_mag_q  <= {NCH{BLANK}};
    end else if (clear) begin
      // Abort any in-flight update; rr_ptr keeps its place in the rotation.
      state_q    <= StIdle;
      ack_q      <= '0;
      hex_sign_q <= {NCH{BLANK}};
      hex_mag_q  <= {NCH{BLANK}};
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: ;
        StGrant: begin
          dec_n_q <= val[4*int'(win_q) +: 4];
          state_q <= StDecode;
        end
        StDecode: begin
          sign_q  <= dec_sign;
          mag_q   <= dec_mag;
          state_q <= StWrite;
        end
        StWrite: begin
          hex_sign_q[7*int'(win_q) +: 7] <= sign_q;
          hex_mag_q[7*int'(win_q) +: 7]  <= mag_q;
          state_q                        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (launch) begin
        win_q    <= winner;
        rr_ptr_q <= rr_ptr_d;
        ack_q    <= grant_d;
        state_q  <= StGrant;
      end
    end
  end

  assign ack      = ack_q & ~{NCH{clear}};
  assign dec_n    = dec_n_q;
  assign hex_sign = hex_sign_q;
  assign hex_mag  = hex_mag_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_tc_hex_scheduler.sv
// Directed bench for tc_hex_scheduler with a behavioural TC-to-7-segment decoder.
module tb_tc_hex_scheduler;

  localparam int NCH = 4;
  localparam logic [27:0] AllBlank = {4{7'h7F}};

  logic            clk;
  logic            reset;
  logic            clear;
  logic [NCH-1:0]  req;
  logic [4*NCH-1:0] val;
  logic [NCH-1:0]  ack;
  logic [3:0]      dec_n;
  logic [6:0]      dec_sign;
  logic [6:0]      dec_mag;
  logic [7*NCH-1:0] hex_sign;
  logic [7*NCH-1:0] hex_mag;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  tc_hex_scheduler #(
    .NCH   (NCH),
    .BLANK (7'h7F)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .req      (req),
    .val      (val),
    .ack      (ack),
    .dec_n    (dec_n),
    .dec_sign (dec_sign),
    .dec_mag  (dec_mag),
    .hex_sign (hex_sign),
    .hex_mag  (hex_mag),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low decoder model: minus sign lights only segment g.
  function automatic logic [6:0] mag_pat(input logic [3:0] n);
    logic [3:0] a;
    a = n[3] ? (~n + 4'd1) : n;
    case (a)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      default: return 7'h00;
    endcase
  endfunction

  assign dec_sign = dec_n[3] ? 7'h3F : 7'h7F;
  assign dec_mag  = mag_pat(dec_n);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear = 1'b0;
    req   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Steps until an ack appears (bounded); drops that channel's req like a real requester.
  task automatic wait_ack(output int idx, output int cycles, input int limit);
    idx    = -1;
    cycles = 0;
    while (idx < 0 && cycles < limit) begin
      step();
      cycles++;
      for (int i = 0; i < NCH; i++) begin
        if (ack[i]) begin
          idx    = i;
          req[i] = 1'b0;
        end
      end
    end
  endtask

  int idx, cyc, hits;

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    req   = '0;
    val   = '0;

    // Reset state and single-channel latency
    do_reset();
    check("rst ack", ack, 4'b0000);
    check("rst dec_n", dec_n, 4'h0);
    check("rst busy", busy, 1'b0);
    check("rst hex_sign", hex_sign, AllBlank);
    check("rst hex_mag", hex_mag, AllBlank);
    val[3:0] = 4'hD;
    req      = 4'b0001;
    step();
    check("t1 ack", ack, 4'b0001);
    check("t1 busy", busy, 1'b1);
    req = '0;
    step();
    check("t1 dec_n", dec_n, 4'hD);
    check("t1 ack low", ack, 4'b0000);
    step();
    check("t1 slot0 early", hex_sign[6:0], 7'h7F);
    step();
    check("t1 slot0 sign", hex_sign[6:0], 7'h3F);
    check("t1 slot0 mag", hex_mag[6:0], 7'h30);
    check("t1 others sign", hex_sign[27:7], {3{7'h7F}});
    check("t1 others mag", hex_mag[27:7], {3{7'h7F}});
    check("t1 idle", busy, 1'b0);

    // All four requesting from reset
    do_reset();
    val = {4'h7, 4'hF, 4'h2, 4'h1};
    req = 4'b1111;
    for (int i = 0; i < NCH; i++) begin
      wait_ack(idx, cyc, 12);
      check("all4 order", 64'(idx), 64'(i));
      check("all4 spacing", 64'(cyc), (i == 0) ? 64'd1 : 64'd3);
    end
    step();
    step();
    step();
    check("all4 sign", hex_sign, {7'h7F, 7'h3F, 7'h7F, 7'h7F});
    check("all4 mag", hex_mag, {7'h78, 7'h79, 7'h24, 7'h79});

    // ch2 served leaves rr_ptr at 3, so ch0 wins over ch2
    req = 4'b0100;
    wait_ack(idx, cyc, 12);
    check("wrap ch2", 64'(idx), 64'd2);
    step();
    step();
    step();
    req = 4'b0101;
    wait_ack(idx, cyc, 12);
    check("wrap first", 64'(idx), 64'd0);
    wait_ack(idx, cyc, 12);
    check("wrap second", 64'(idx), 64'd2);
    check("wrap spacing", 64'(cyc), 64'd3);
    step();
    step();
    step();

    // clear during DECODE discards the ch1 update
    do_reset();
    val = {4'h0, 4'h0, 4'h8, 4'h1};
    req = 4'b0001;
    wait_ack(idx, cyc, 12);
    step();
    step();
    step();
    check("clr pre slot0", hex_mag[6:0], 7'h79);
    req = 4'b0010;
    wait_ack(idx, cyc, 12);
    check("clr grant ch1", 64'(idx), 64'd1);
    step();
    check("clr dec_n", dec_n, 4'h8);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr busy", busy, 1'b0);
    check("clr ack", ack, 4'b0000);
    check("clr mag", hex_mag, AllBlank);
    step();
    step();
    check("clr sign later", hex_sign, AllBlank);
    check("clr mag later", hex_mag, AllBlank);
    req = 4'b0101;
    wait_ack(idx, cyc, 12);
    check("clr keeps rr_ptr", 64'(idx), 64'd2);

    // reset + clear together in WRITE
    wait_ack(idx, cyc, 12);
    check("rc grant ch0", 64'(idx), 64'd0);
    step();
    step();
    reset = 1'b1;
    clear = 1'b1;
    step();
    reset = 1'b0;
    clear = 1'b0;
    req   = '0;
    check("rc ack", ack, 4'b0000);
    check("rc dec_n", dec_n, 4'h0);
    check("rc busy", busy, 1'b0);
    check("rc sign", hex_sign, AllBlank);
    check("rc mag", hex_mag, AllBlank);
    req = 4'b0011;
    wait_ack(idx, cyc, 12);
    check("rc rr_ptr zero", 64'(idx), 64'd0);
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // ch3 pulse outside arbitration is dropped
    do_reset();
    val = {4'h5, 4'h0, 4'h3, 4'h0};
    req = 4'b0010;
    wait_ack(idx, cyc, 12);
    check("drop grant ch1", 64'(idx), 64'd1);
    step();
    req = 4'b1000;
    step();
    req  = '0;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack[3]) hits++;
    end
    check("drop no ack3", 64'(hits), 64'd0);
    check("drop slot3 sign", hex_sign[27:21], 7'h7F);
    check("drop slot3 mag", hex_mag[27:21], 7'h7F);
    check("drop slot1 mag", hex_mag[13:7], 7'h30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
